// File: rtl/stripe_scheduler.sv
// Stripe scheduler: walks a query in PE_NUM-base stripes through one banded PE array,
// chaining each stripe's reference start column and tracking the job-level best score.
module stripe_scheduler #(
  parameter int unsigned PE_NUM  = 64,
  parameter int unsigned SCORE_W = 14,
  parameter int unsigned REF_W   = 10,
  parameter int unsigned QRY_W   = 12,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_job_valid,
  output logic                            o_job_ready,
  input  logic [QRY_W-1:0]                i_qry_len,
  input  logic [REF_W-1:0]                i_ref_len,
  output logic [QRY_W-$clog2(PE_NUM)-1:0] o_qry_addr,
  input  logic [2*PE_NUM-1:0]             i_qry_data,
  output logic [REF_W-1:0]                o_ref_addr,
  input  logic [1:0]                      i_ref_data,
  output logic                            o_pe_start,
  output logic [2*PE_NUM-1:0]             o_pe_B,
  output logic [1:0]                      o_pe_A,
  input  logic                            i_pe_stripe_end,
  input  logic [REF_W-1:0]                i_pe_start_position,
  input  logic [SCORE_W-1:0]              i_pe_max_score,
  output logic                            o_done,
  output logic                            o_err,
  output logic [SCORE_W-1:0]              o_best_score,
  output logic [QRY_W-$clog2(PE_NUM)-1:0] o_best_stripe,
  output logic                            o_busy
);

  localparam int unsigned LaneW = $clog2(PE_NUM);
  localparam int unsigned AddrW = QRY_W - LaneW;
  // One extra bit so the stripe counter can reach n_stripes when the query fills memory.
  localparam int unsigned CntW  = AddrW + 1;
  localparam int unsigned WdW   = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0]     WdLast   = WdW'(TIMEOUT - 1);
  localparam logic [SCORE_W-1:0] ScoreMin = {1'b1, {(SCORE_W-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStream,
    StDrain,
    StUpdate,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [QRY_W-1:0]     qry_len_q;
  logic [REF_W-1:0]     ref_len_q;
  logic [CntW-1:0]      n_stripes_q;
  logic [CntW-1:0]      stripe_q, stripe_d, stripe_inc;
  logic [REF_W:0]       ref_off_q, ref_off_d, ref_off_sum;
  logic [2*PE_NUM-1:0]  b_q, b_load;
  logic [QRY_W-1:0]     qry_rem;
  logic [REF_W-1:0]     cnt_q;
  logic [WdW-1:0]       wd_q;
  logic [REF_W-1:0]     addr_q;
  logic [SCORE_W-1:0]   cap_max_q;
  logic [REF_W-1:0]     cap_pos_q;
  logic [SCORE_W-1:0]   best_q, best_d;
  logic [AddrW-1:0]     best_stripe_q, best_stripe_d;
  logic                 err_q, err_d;
  logic [SCORE_W-1:0]   out_best_q;
  logic [AddrW-1:0]     out_stripe_q;
  logic                 accept;
  logic                 stripe_end_seen;

  assign accept          = (state_q == StIdle) & i_job_valid;
  assign stripe_end_seen = ((state_q == StStream) | (state_q == StDrain)) & i_pe_stripe_end;
  assign stripe_inc      = stripe_q + 1'b1;
  assign ref_off_sum     = ref_off_q + (REF_W+1)'(cap_pos_q);

  // Query lanes past the end of the query are blanked so the PE array sees no stale bases.
  always_comb begin
    qry_rem = qry_len_q - {stripe_q[AddrW-1:0], {LaneW{1'b0}}};
    b_load  = '0;
    for (int unsigned i = 0; i < PE_NUM; i++) begin
      if (QRY_W'(i) < qry_rem) b_load[2*i +: 2] = i_qry_data[2*i +: 2];
    end
  end

  always_comb begin
    state_d       = state_q;
    stripe_d      = stripe_q;
    ref_off_d     = ref_off_q;
    best_d        = best_q;
    best_stripe_d = best_stripe_q;
    err_d         = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_job_valid) begin
          stripe_d      = '0;
          ref_off_d     = '0;
          best_d        = ScoreMin;
          best_stripe_d = '0;
          if (i_qry_len == '0 || i_ref_len == '0) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            err_d   = 1'b0;
            state_d = StFetch;
          end
        end
      end
      StFetch: state_d = StLoad;
      StLoad:  state_d = StStream;
      StStream: begin
        if (i_pe_stripe_end)           state_d = StUpdate;
        else if (cnt_q == REF_W'(1))   state_d = StDrain;
      end
      StDrain: begin
        if (i_pe_stripe_end) begin
          state_d = StUpdate;
        end else if (wd_q == WdLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StUpdate: begin
        // Strict compare: a tie keeps the earlier stripe.
        if ($signed(cap_max_q) > $signed(best_q)) begin
          best_d        = cap_max_q;
          best_stripe_d = stripe_q[AddrW-1:0];
        end
        ref_off_d = ref_off_sum;
        stripe_d  = stripe_inc;
        if (stripe_inc == n_stripes_q || ref_off_sum >= {1'b0, ref_len_q}) state_d = StDone;
        else                                                                state_d = StFetch;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StIdle;
      qry_len_q     <= '0;
      ref_len_q     <= '0;
      n_stripes_q   <= '0;
      stripe_q      <= '0;
      ref_off_q     <= '0;
      b_q           <= '0;
      cnt_q         <= '0;
      wd_q          <= '0;
      addr_q        <= '0;
      cap_max_q     <= '0;
      cap_pos_q     <= '0;
      best_q        <= ScoreMin;
      best_stripe_q <= '0;
      err_q         <= 1'b0;
      out_best_q    <= ScoreMin;
      out_stripe_q  <= '0;
    end else begin
      state_q       <= state_d;
      stripe_q      <= stripe_d;
      ref_off_q     <= ref_off_d;
      best_q        <= best_d;
      best_stripe_q <= best_stripe_d;
      err_q         <= err_d;

      if (accept) begin
        qry_len_q   <= i_qry_len;
        ref_len_q   <= i_ref_len;
        n_stripes_q <= CntW'((i_qry_len + PE_NUM - 1) >> LaneW);
      end

      // Address leads the data by one cycle: LOAD presents ref_off, STREAM cycle k reads k+1.
      if (state_q == StFetch) begin
        addr_q <= ref_off_q[REF_W-1:0];
      end else if (state_q == StLoad || state_q == StStream) begin
        addr_q <= addr_q + 1'b1;
      end

      if (state_q == StLoad) begin
        b_q   <= b_load;
        cnt_q <= ref_len_q - ref_off_q[REF_W-1:0];
      end else if (state_q == StStream) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (state_q == StDrain) wd_q <= wd_q + 1'b1;
      else                    wd_q <= '0;

      // The PE array clears its results the cycle after stripe end, so hold them here.
      if (stripe_end_seen) begin
        cap_max_q <= i_pe_max_score;
        cap_pos_q <= i_pe_start_position;
      end

      if (state_d == StDone) begin
        out_best_q   <= best_d;
        out_stripe_q <= best_stripe_d;
      end
    end
  end

  assign o_job_ready   = (state_q == StIdle);
  assign o_busy        = (state_q != StIdle);
  assign o_done        = (state_q == StDone);
  assign o_err         = (state_q == StDone) & err_q;
  assign o_pe_start    = (state_q == StStream) & ~i_pe_stripe_end;
  assign o_pe_B        = (state_q == StStream) ? b_q : '0;
  assign o_pe_A        = (state_q == StStream) ? i_ref_data : 2'b00;
  assign o_qry_addr    = stripe_q[AddrW-1:0];
  assign o_ref_addr    = addr_q;
  assign o_best_score  = out_best_q;
  assign o_best_stripe = out_stripe_q;

endmodule

// File: tb/tb_stripe_scheduler.sv
// Bench for stripe_scheduler: random memories and PE responses, checked against a
// stripe-level model of the job (offsets, stream lengths, best score, completion time).
module tb_stripe_scheduler;

  localparam int PE_NUM  = 64;
  localparam int SCORE_W = 14;
  localparam int REF_W   = 10;
  localparam int QRY_W   = 12;
  localparam int TIMEOUT = 1023;
  localparam int NEVER   = 1000000;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n = 1'b0;
  logic                  i_job_valid;
  logic                  o_job_ready;
  logic [QRY_W-1:0]      i_qry_len;
  logic [REF_W-1:0]      i_ref_len;
  logic [QRY_W-7:0]      o_qry_addr;
  logic [2*PE_NUM-1:0]   i_qry_data;
  logic [REF_W-1:0]      o_ref_addr;
  logic [1:0]            i_ref_data;
  logic                  o_pe_start;
  logic [2*PE_NUM-1:0]   o_pe_B;
  logic [1:0]            o_pe_A;
  logic                  i_pe_stripe_end;
  logic [REF_W-1:0]      i_pe_start_position;
  logic [SCORE_W-1:0]    i_pe_max_score;
  logic                  o_done;
  logic                  o_err;
  logic [SCORE_W-1:0]    o_best_score;
  logic [QRY_W-7:0]      o_best_stripe;
  logic                  o_busy;

  stripe_scheduler dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_job_valid         (i_job_valid),
    .o_job_ready         (o_job_ready),
    .i_qry_len           (i_qry_len),
    .i_ref_len           (i_ref_len),
    .o_qry_addr          (o_qry_addr),
    .i_qry_data          (i_qry_data),
    .o_ref_addr          (o_ref_addr),
    .i_ref_data          (i_ref_data),
    .o_pe_start          (o_pe_start),
    .o_pe_B              (o_pe_B),
    .o_pe_A              (o_pe_A),
    .i_pe_stripe_end     (i_pe_stripe_end),
    .i_pe_start_position (i_pe_start_position),
    .i_pe_max_score      (i_pe_max_score),
    .o_done              (o_done),
    .o_err               (o_err),
    .o_best_score        (o_best_score),
    .o_best_stripe       (o_best_stripe),
    .o_busy              (o_busy)
  );

  always #5 i_clk = ~i_clk;

  logic [2*PE_NUM-1:0] qry_mem [64];
  logic [1:0]          ref_mem [1024];

  // Synchronous-read memories: data follows the address by one clock.
  always @(posedge i_clk) begin
    i_qry_data <= qry_mem[o_qry_addr];
    i_ref_data <= ref_mem[o_ref_addr];
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int end_after [64];
  int spos [64];
  int smax [64];
  int hold_best = -8192;
  int hold_bs = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] lo14(input int v);
    return v[13:0];
  endfunction

  // Query word for stripe s with every lane whose query position is past ql blanked.
  function automatic logic [127:0] exp_b(input int s, input int ql);
    logic [127:0] w;
    w = qry_mem[s];
    for (int i = 0; i < PE_NUM; i++) if (s * PE_NUM + i >= ql) w[2*i +: 2] = 2'b00;
    return w;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_start"}, o_pe_start, 0);
    check({tag, "_B"}, o_pe_B, 0);
    check({tag, "_A"}, o_pe_A, 0);
    check({tag, "_qaddr"}, o_qry_addr, 0);
    check({tag, "_raddr"}, o_ref_addr, 0);
    check({tag, "_best"}, o_best_score, 14'h2000);
    check({tag, "_bstripe"}, o_best_stripe, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_ready"}, o_job_ready, 1);
  endtask

  task automatic run_job(input int ql, input int rl, input int abort_k);
    int n, off, best, bs, nrun, terr, exp_stripes;
    int exp_off [64];
    int exp_slen [64];
    int cur, since, scnt, exp_start, exp_done, elen;
    bit done_seen, se;
    // Stripe-level reference model of the whole job.
    n = (ql + PE_NUM - 1) / PE_NUM;
    off = 0; best = -8192; bs = 0; nrun = 0; terr = 0;
    if (ql == 0 || rl == 0) begin
      terr = 1;
    end else begin
      for (int s = 0; s < n; s++) begin
        exp_off[s] = off;
        exp_slen[s] = rl - off;
        nrun++;
        if (end_after[s] >= exp_slen[s] + TIMEOUT) begin
          terr = 1;
          break;
        end
        if (smax[s] > best) begin
          best = smax[s];
          bs = s;
        end
        off += spos[s];
        if (off >= rl) break;
      end
    end
    exp_stripes = (terr != 0 && nrun > 0) ? nrun - 1 : nrun;

    @(posedge i_clk); #1; cyc++;
    i_job_valid = 1'b1; i_qry_len = QRY_W'(ql); i_ref_len = REF_W'(rl);
    i_pe_stripe_end = 1'b0;
    #1;
    check("accept_ready", o_job_ready, 1);
    check("hold_best", o_best_score, lo14(hold_best));
    check("hold_stripe", o_best_stripe, hold_bs);
    exp_start = cyc + 3;
    exp_done = (ql == 0 || rl == 0) ? cyc + 1 : -1;

    cur = 0; since = -1; scnt = 0; done_seen = 0;
    for (int c = 0; c < 30000 && !done_seen; c++) begin
      @(posedge i_clk); #1; cyc++;
      i_job_valid = 1'b0;
      i_qry_len = QRY_W'($urandom);
      i_ref_len = REF_W'($urandom);
      i_pe_stripe_end = 1'b0;
      i_pe_max_score = SCORE_W'($urandom);
      i_pe_start_position = REF_W'($urandom);
      if (since >= 0) since++;
      se = (since >= 0 && cur < nrun && since == end_after[cur]);
      if (se) begin
        i_pe_stripe_end = 1'b1;
        i_pe_max_score = lo14(smax[cur]);
        i_pe_start_position = REF_W'(spos[cur]);
      end
      #1;
      if (!o_done) check("busy", o_busy, 1);
      if (o_pe_start) begin
        if (since < 0) begin
          since = 0;
          scnt = 0;
          check("stream_start_cycle", cyc, exp_start);
          if (cur == nrun - 1 && terr != 0) exp_done = cyc + exp_slen[cur] + TIMEOUT;
        end
        if (cur < nrun) begin
          check("pe_B", o_pe_B, exp_b(cur, ql));
          check("pe_A", o_pe_A, ref_mem[(exp_off[cur] + since) % 1024]);
        end
        scnt++;
      end
      if (abort_k >= 0 && since == abort_k) begin
        i_rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        hold_best = -8192;
        hold_bs = 0;
        return;
      end
      if (se) begin
        elen = (end_after[cur] < exp_slen[cur]) ? end_after[cur] : exp_slen[cur];
        check("start_gated", o_pe_start, 0);
        check("stream_len", scnt, elen);
        cur++;
        since = -1;
        if (cur == nrun) exp_done = cyc + 2;
        else             exp_start = cyc + 4;
      end
      if (o_done) begin
        done_seen = 1;
        check("done_cycle", cyc, exp_done);
        check("err", o_err, terr);
        check("best_score", o_best_score, lo14(best));
        check("best_stripe", o_best_stripe, bs);
        check("stripes_run", cur, exp_stripes);
      end
    end
    check("done_seen", done_seen, 1);
    hold_best = best;
    hold_bs = bs;
    @(posedge i_clk); #2; cyc++;
    check("done_pulse", o_done, 0);
    check("idle_ready", o_job_ready, 1);
  endtask

  initial begin
    int ql, rl;
    for (int i = 0; i < 64; i++) qry_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 1024; i++) ref_mem[i] = 2'($urandom);
    i_job_valid = 1'b0; i_qry_len = '0; i_ref_len = '0;
    i_pe_stripe_end = 1'b0; i_pe_start_position = '0; i_pe_max_score = '0;
    repeat (3) @(posedge i_clk);
    #2;
    check_reset_vals("reset");
    @(negedge i_clk) i_rst_n = 1'b1;

    // Single stripe, PE ends 80 cycles into drain.
    end_after[0] = 180; spos[0] = 0; smax[0] = 57;
    run_job(64, 100, -1);

    // Three stripes with chained offsets and a tie on the best score.
    end_after[0] = 503; spos[0] = 10; smax[0] = 30;
    end_after[1] = 493; spos[1] = 20; smax[1] = 90;
    end_after[2] = 473; spos[2] = 7;  smax[2] = 90;
    run_job(130, 500, -1);

    // Start position beyond the reference ends the job after one stripe.
    end_after[0] = 50; spos[0] = 45; smax[0] = 5;
    run_job(192, 40, -1);

    // Early stripe end during stream.
    end_after[0] = 5;   spos[0] = 0; smax[0] = -100;
    end_after[1] = 210; spos[1] = 3; smax[1] = -200;
    run_job(128, 200, -1);

    // Scores at the signed extremes.
    end_after[0] = 60; spos[0] = 0; smax[0] = -8192;
    end_after[1] = 60; spos[1] = 0; smax[1] = -8192;
    run_job(128, 50, -1);
    end_after[0] = 55; spos[0] = 1; smax[0] = -5;
    end_after[1] = 55; spos[1] = 1; smax[1] = 8191;
    run_job(100, 50, -1);

    // Watchdog expiry, then zero-length jobs.
    end_after[0] = NEVER; spos[0] = 0; smax[0] = 1;
    run_job(64, 30, -1);
    run_job(0, 50, -1);
    run_job(50, 0, -1);

    // Reset mid-stream, then a normal job.
    for (int s = 0; s < 64; s++) begin
      end_after[s] = 320; spos[s] = 0; smax[s] = s;
    end
    run_job(256, 300, 50);
    #10;
    @(negedge i_clk) i_rst_n = 1'b1;
    end_after[0] = 70; spos[0] = 2; smax[0] = 12;
    run_job(64, 60, -1);

    for (int j = 0; j < 8; j++) begin
      ql = $urandom_range(1, 400);
      rl = $urandom_range(1, 300);
      for (int s = 0; s < 64; s++) begin
        end_after[s] = $urandom_range(1, rl + 20);
        spos[s] = $urandom_range(0, rl / 3);
        smax[s] = int'($urandom_range(0, 16383)) - 8192;
      end
      run_job(ql, rl, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
